// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM encoding for the binary-to-BCD converter
package bcd_pkg;

  localparam int BIN_W_DEF  = 10;
  localparam int DIGITS_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Digits at or above this value are corrected by +3 before each shift
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - per-digit add-3 correction for double dabble
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);

  // Largest input that matters is 9, so the result never exceeds 4'b1100
  assign corrected = (nibble >= ADD3_THRESH) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - multi-cycle shift-and-add-3 binary-to-BCD converter
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  logic [1:0]       state;
  logic [BIN_W-1:0] bin_sr;
  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] corr;
  logic [SCR_W-1:0] scratch_next;
  logic [CNT_W-1:0] step;
  logic             accept;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
        .nibble    (scratch[4*g +: 4]),
        .corrected (corr[4*g +: 4])
      );
    end
  endgenerate

  // Corrected scratch shifted left, pulling in the next binary MSB
  assign scratch_next = {corr[SCR_W-2:0], bin_sr[BIN_W-1]};

  // A new conversion may begin from IDLE or in the DONE cycle itself
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // FSM, step counter, shift registers and registered outputs
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state   <= ST_IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          busy <= accept;
          if (accept) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            step    <= '0;
            state   <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_next;
          bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
          step    <= step + 1'b1;
          if (step == LAST_STEP) begin
            bcd_out <= scratch_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  bin_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;

  int tests_run = 0;
  int failed = 0;
  int done_count = 0;
  logic        rst_prev = 1'b1;
  logic [15:0] last_bcd = '0;
  logic [15:0] exp_q[$];

  bin2bcd_seq dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .start         (start),
    .bin_in        (bin_in),
    .busy          (busy),
    .done          (done),
    .bcd_out       (bcd_out)
  );

  always #10 clk = ~clk;

  // Remember whether the last edge applied reset
  always @(posedge clk) rst_prev = rst;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Monitor: scoreboard compare on done, exclusivity, output stability
  always @(negedge clk) begin
    if (rst_prev) begin
      last_bcd = bcd_out;
    end else begin
      tests_run++;
      if (busy && done) begin
        failed++;
        $display("FAIL busy_done_exclusive: busy=%0b done=%0b required not both high", busy, done);
      end
      if (done) begin
        done_count++;
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_done: bcd_out=%h with no conversion pending", bcd_out);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bcd_out !== e) begin
            failed++;
            $display("FAIL bcd_result: got %h required %h", bcd_out, e);
          end
        end
        last_bcd = bcd_out;
      end else begin
        tests_run++;
        if (bcd_out !== last_bcd) begin
          failed++;
          $display("FAIL bcd_stable: got %h required %h", bcd_out, last_bcd);
        end
      end
    end
  end

  // Must be entered at a falling edge; returns done latency (-1 if none)
  task automatic run_conv(input int v, input int inj_at, input bit inj_rst,
                          output int lat, output int busy_cyc);
    start = 1'b1;
    bin_in = 10'(v);
    exp_q.push_back(to_bcd(v));
    lat = -1;
    busy_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (inj_at != 0 && i == inj_at) begin
        if (inj_rst) rst = 1'b1;
        else begin
          start = 1'b1;
          bin_in = 10'd5;
        end
      end
      if (inj_at != 0 && i == inj_at + 1) begin
        start = 1'b0;
        if (inj_rst) begin
          rst = 1'b0;
          tests_run++;
          if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
            failed++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b bcd=%h required 0 0 0000", busy, done, bcd_out);
          end
          exp_q.delete();
        end
      end
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_timing(input string name, input int lat, input int busy_cyc);
    tests_run++;
    if (lat !== 11) begin
      failed++;
      $display("FAIL %s_latency: got %0d required 11", name, lat);
    end
    tests_run++;
    if (busy_cyc !== 10) begin
      failed++;
      $display("FAIL %s_busy_cycles: got %0d required 10", name, busy_cyc);
    end
  endtask

  task automatic test_reset();
    int lat, bc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
      failed++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h required 0 0 0000", busy, done, bcd_out);
    end
    rst = 1'b0;
    @(negedge clk);
    run_conv(0, 0, 1'b0, lat, bc);
    check_timing("zero", lat, bc);
  endtask

  task automatic test_values();
    int vals[4] = '{1023, 999, 9, 10};
    int lat, bc;
    foreach (vals[k]) begin
      repeat (2) @(negedge clk);
      run_conv(vals[k], 0, 1'b0, lat, bc);
      check_timing($sformatf("val%0d", vals[k]), lat, bc);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc, d0;
    repeat (2) @(negedge clk);
    d0 = done_count;
    run_conv(100, 3, 1'b0, lat, bc);
    check_timing("ignore", lat, bc);
    repeat (15) @(negedge clk);
    tests_run++;
    if (done_count - d0 !== 1) begin
      failed++;
      $display("FAIL ignore_single_done: got %0d pulses required 1", done_count - d0);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    repeat (2) @(negedge clk);
    run_conv(512, 0, 1'b0, lat, bc);
    check_timing("b2b_first", lat, bc);
    run_conv(37, 0, 1'b0, lat, bc);
    check_timing("b2b_second", lat, bc);
  endtask

  task automatic test_mid_reset();
    int lat, bc, d0;
    repeat (2) @(negedge clk);
    d0 = done_count;
    run_conv(777, 5, 1'b1, lat, bc);
    tests_run++;
    if (lat !== -1 || done_count !== d0) begin
      failed++;
      $display("FAIL mid_reset_no_done: latency=%0d pulses=%0d required none", lat, done_count - d0);
    end
    run_conv(42, 0, 1'b0, lat, bc);
    check_timing("after_reset", lat, bc);
  endtask

  task automatic test_sweep();
    int lat, bc;
    for (int v = 0; v < 1024; v++) begin
      run_conv(v, 0, 1'b0, lat, bc);
      tests_run++;
      if (lat !== 11) begin
        failed++;
        $display("FAIL sweep_latency: v=%0d got %0d required 11", v, lat);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    repeat (5) @(negedge clk);
    tests_run++;
    if (exp_q.size() !== 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d results outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
